ifu_fetch: RTL and testbench

- Instruction fetch unit; sits directly upstream of the instruction cache.
- Owns the PC and issues one AXI-Lite read per instruction to the cache.
- Buffers the returned word in a single output register and hands {pc, inst} to the IDU through a valid/ready handshake.
- Accepts redirects (branch, jump, trap, fence.i) from the write-back stage; squashes any stale in-flight response and forwards the fence.i flush pulse to the cache.

---
 rtl/ifu_fetch_pkg.sv | 17 +
 rtl/ifu_fetch.sv | 161 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: AXI response codes,
// the default reset PC and the fetch state encoding.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        RESP = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one AXI-Lite read at a time to
// the instruction cache and hands {pc, inst, fault} to the IDU from a single register.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] ic_araddr,
    output logic            ic_arvalid,
    input  logic            ic_arready,
    input  logic [XLEN-1:0] ic_rdata,
    input  logic [1:0]      ic_rresp,
    input  logic            ic_rvalid,
    output logic            ic_rready,
    output logic            ic_fence_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_fence_i,
    output logic            idu_valid,
    input  logic            idu_ready,
    output logic [XLEN-1:0] idu_pc,
    output logic [XLEN-1:0] idu_inst,
    output logic            idu_fault
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    fetch_state_t    state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic            squash_r, squash_s;
    logic            out_valid_r, out_valid_s;
    logic            fence_r;
    logic [XLEN-1:0] out_pc_r, out_inst_r;
    logic            out_fault_r;
    logic            load_s, slot_free_s, ar_hs_s, r_hs_s;
    logic [XLEN-1:0] redirect_tgt_s;

    assign slot_free_s    = !out_valid_r || idu_ready;
    assign redirect_tgt_s = {redirect_pc[XLEN-1:2], 2'b00};

    // The AR is held off during the fence.i pulse so the flush reaches the cache first.
    assign ic_araddr  = pc_r;
    assign ic_arvalid = (state_r == REQ) && !fence_r;
    assign ic_rready  = (state_r == RESP) && (squash_r || slot_free_s);
    assign ic_fence_i = fence_r;
    assign ar_hs_s    = ic_arvalid && ic_arready;
    assign r_hs_s     = ic_rready && ic_rvalid;

    assign idu_valid = out_valid_r;
    assign idu_pc    = out_pc_r;
    assign idu_inst  = out_inst_r;
    assign idu_fault = out_fault_r;

    // Next-state, next-pc, squash and output-slot occupancy.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        squash_s    = squash_r;
        load_s      = 1'b0;
        out_valid_s = out_valid_r && !idu_ready;
        if (redirect_valid) begin
            pc_s        = redirect_tgt_s;
            out_valid_s = 1'b0;
            case (state_r)
                REQ: begin
                    if (ar_hs_s) begin
                        squash_s = 1'b1;
                        state_s  = RESP;
                    end else begin
                        squash_s = 1'b0;
                        state_s  = REQ;
                    end
                end
                RESP: begin
                    if (r_hs_s) begin
                        squash_s = 1'b0;
                        state_s  = REQ;
                    end else begin
                        squash_s = 1'b1;
                        state_s  = RESP;
                    end
                end
                default: begin
                    squash_s = 1'b0;
                    state_s  = REQ;
                end
            endcase
        end else begin
            case (state_r)
                REQ: begin
                    if (ar_hs_s) begin
                        state_s = RESP;
                    end else begin
                        state_s = REQ;
                    end
                end
                RESP: begin
                    if (r_hs_s && squash_r) begin
                        squash_s = 1'b0;
                        state_s  = REQ;
                    end else if (r_hs_s) begin
                        load_s      = 1'b1;
                        out_valid_s = 1'b1;
                        pc_s        = pc_r + PC_STEP;
                        state_s     = slot_free_s ? REQ : HOLD;
                    end else begin
                        state_s = RESP;
                    end
                end
                HOLD: begin
                    if (idu_ready) begin
                        state_s = REQ;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = REQ;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= REQ;
            pc_r        <= RESET_PC;
            squash_r    <= 1'b0;
            out_valid_r <= 1'b0;
            fence_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            squash_r    <= squash_s;
            out_valid_r <= out_valid_s;
            fence_r     <= redirect_valid && redirect_fence_i;
        end
    end

    // Output register holding the instruction presented to the IDU.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc_r    <= '0;
            out_inst_r  <= '0;
            out_fault_r <= 1'b0;
        end else if (load_s) begin
            out_pc_r    <= pc_r;
            out_inst_r  <= ic_rdata;
            out_fault_r <= (ic_rresp != AXI_RESP_OKAY);
        end else begin
            out_pc_r    <= out_pc_r;
            out_inst_r  <= out_inst_r;
            out_fault_r <= out_fault_r;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a behavioural instruction cache of
// configurable latency, a stream table and a table of redirect scenarios.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_araddr;
    logic        ic_arvalid;
    logic        ic_arready;
    logic [31:0] ic_rdata;
    logic [1:0]  ic_rresp;
    logic        ic_rvalid;
    logic        ic_rready;
    logic        ic_fence_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_fence_i;
    logic        idu_valid;
    logic        idu_ready;
    logic [31:0] idu_pc;
    logic [31:0] idu_inst;
    logic        idu_fault;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h3000_0000)) dut (
        .clk(clk), .rst(rst),
        .ic_araddr(ic_araddr), .ic_arvalid(ic_arvalid), .ic_arready(ic_arready),
        .ic_rdata(ic_rdata), .ic_rresp(ic_rresp), .ic_rvalid(ic_rvalid), .ic_rready(ic_rready),
        .ic_fence_i(ic_fence_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_fence_i(redirect_fence_i),
        .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_pc(idu_pc), .idu_inst(idu_inst),
        .idu_fault(idu_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } idu_rec_t;

    typedef struct {
        string       name;
        int          lat;
        int          redir_at;
        logic [31:0] rpc;
        logic        fence;
        int          ar_idx;
        logic [31:0] exp_ar;
        logic [31:0] exp_pc;
        logic [31:0] forbid_pc;
    } scen_t;

    idu_rec_t    idu_log[$];
    logic [31:0] ar_log[$];
    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          wait_cnt;
    bit          pend;
    logic [31:0] req_addr;
    logic [31:0] fault_addr;
    int          fence_cnt;
    int          overlap_cnt;
    logic        s_rready, s_rvalid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock: sample handshakes at the negedge, then advance the cache model.
    task automatic tick();
        logic        ar_hs, r_hs;
        logic [31:0] addr;
        idu_rec_t    rec;
        @(negedge clk);
        ar_hs    = ic_arvalid && ic_arready;
        r_hs     = ic_rvalid && ic_rready;
        addr     = ic_araddr;
        s_rready = ic_rready;
        s_rvalid = ic_rvalid;
        if (ic_fence_i) begin
            fence_cnt++;
            if (ic_arvalid) overlap_cnt++;
        end
        if (ar_hs) ar_log.push_back(addr);
        if (idu_valid && idu_ready && !redirect_valid) begin
            rec.pc    = idu_pc;
            rec.inst  = idu_inst;
            rec.fault = idu_fault;
            idu_log.push_back(rec);
        end
        @(posedge clk);
        #1;
        if (r_hs) ic_rvalid = 1'b0;
        if (ar_hs) begin
            pend     = 1'b1;
            wait_cnt = lat;
            req_addr = addr;
        end
        if (pend) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                pend      = 1'b0;
                ic_rvalid = 1'b1;
                ic_rdata  = mem_word(req_addr);
                ic_rresp  = (req_addr == fault_addr) ? 2'b10 : 2'b00;
            end
        end
    endtask

    task automatic do_reset(input int latency);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_fence_i = 1'b0;
        redirect_pc = 32'h0;
        ic_rvalid = 1'b0;
        ic_rdata = 32'h0;
        ic_rresp = 2'b00;
        pend = 1'b0;
        wait_cnt = 0;
        lat = latency;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ar_log.delete();
        idu_log.delete();
        fence_cnt = 0;
        overlap_cnt = 0;
    endtask

    task automatic check_idu(input string name, input int idx, input logic [31:0] pc,
                             input logic fault);
        if (idx < idu_log.size()) begin
            check32({name, "_pc"}, idu_log[idx].pc, pc);
            check32({name, "_inst"}, idu_log[idx].inst, mem_word(pc));
            check32({name, "_fault"}, {31'd0, idu_log[idx].fault}, {31'd0, fault});
        end else begin
            checks++;
            failures++;
            $display("FAIL %s missing: log size=%0d required index=%0d", name, idu_log.size(), idx);
        end
    endtask

    task automatic check_ar(input string name, input int idx, input logic [31:0] exp);
        if (idx < ar_log.size()) begin
            check32(name, ar_log[idx], exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s missing: ar count=%0d required index=%0d", name, ar_log.size(), idx);
        end
    endtask

    idu_rec_t stream[4];
    scen_t    scen[5];

    initial begin
        int n0;
        int hits;

        stream[0] = '{pc: 32'h3000_0000, inst: 32'h0, fault: 1'b0};
        stream[1] = '{pc: 32'h3000_0004, inst: 32'h0, fault: 1'b0};
        stream[2] = '{pc: 32'h3000_0008, inst: 32'h0, fault: 1'b1};
        stream[3] = '{pc: 32'h3000_000C, inst: 32'h0, fault: 1'b0};

        scen[0] = '{"redir_resp", 1, 3, 32'h8000_0010, 1'b0, 2, 32'h8000_0010, 32'h8000_0010, 32'h3000_0004};
        scen[1] = '{"redir_arhs", 1, 2, 32'h8000_0000, 1'b0, 2, 32'h8000_0000, 32'h8000_0000, 32'h3000_0004};
        scen[2] = '{"fence_i", 1, 1, 32'h8000_0100, 1'b1, 1, 32'h8000_0100, 32'h8000_0100, 32'h3000_0000};
        scen[3] = '{"squash_misalign", 3, 1, 32'h8000_0013, 1'b0, 1, 32'h8000_0010, 32'h8000_0010, 32'h3000_0000};
        scen[4] = '{"pc_wrap", 1, 1, 32'hFFFF_FFFC, 1'b0, 2, 32'h0000_0000, 32'hFFFF_FFFC, 32'h3000_0000};

        ic_arready = 1'b1;

        // Streaming with a faulting word at 0x3000_0008.
        idu_ready  = 1'b1;
        fault_addr = 32'h3000_0008;
        do_reset(1);
        #1;
        check32("rst_arvalid", {31'd0, ic_arvalid}, 32'd1);
        check32("rst_rready", {31'd0, ic_rready}, 32'd0);
        check32("rst_idu_valid", {31'd0, idu_valid}, 32'd0);
        check32("rst_fence_i", {31'd0, ic_fence_i}, 32'd0);
        check32("rst_araddr", ic_araddr, 32'h3000_0000);
        repeat (10) tick();
        check32("stream_ar_count", ar_log.size(), 32'd5);
        check32("stream_idu_count", idu_log.size(), 32'd4);
        for (int i = 0; i < 5; i++) check_ar($sformatf("stream_ar%0d", i), i, 32'h3000_0000 + 32'(i * 4));
        for (int i = 0; i < 4; i++) check_idu($sformatf("stream_idu%0d", i), i, stream[i].pc, stream[i].fault);

        // Back-pressure: IDU stalls, only one more AR goes out and its data waits.
        idu_ready  = 1'b0;
        fault_addr = 32'hFFFF_FFFF;
        do_reset(1);
        repeat (7) tick();
        check32("bp_ar_count", ar_log.size(), 32'd2);
        check_ar("bp_ar1", 1, 32'h3000_0004);
        check32("bp_idu_count", idu_log.size(), 32'd0);
        check32("bp_rvalid", {31'd0, s_rvalid}, 32'd1);
        check32("bp_rready", {31'd0, s_rready}, 32'd0);
        idu_ready = 1'b1;
        repeat (6) tick();
        check32("bp_idu_count_after", idu_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_idu($sformatf("bp_idu%0d", i), i, 32'h3000_0000 + 32'(i * 4), 1'b0);

        // Redirect scenarios.
        for (int s = 0; s < 5; s++) begin
            idu_ready = 1'b1;
            do_reset(scen[s].lat);
            repeat (scen[s].redir_at) tick();
            n0 = idu_log.size();
            redirect_valid   = 1'b1;
            redirect_pc      = scen[s].rpc;
            redirect_fence_i = scen[s].fence;
            tick();
            redirect_valid   = 1'b0;
            redirect_fence_i = 1'b0;
            redirect_pc      = 32'h0;
            repeat (10) tick();
            check_ar({scen[s].name, "_next_ar"}, scen[s].ar_idx, scen[s].exp_ar);
            check_idu({scen[s].name, "_first"}, n0, scen[s].exp_pc, 1'b0);
            hits = 0;
            foreach (idu_log[i]) if (idu_log[i].pc == scen[s].forbid_pc) hits++;
            check32({scen[s].name, "_stale_seen"}, hits, 32'd0);
            check32({scen[s].name, "_fence_pulses"}, fence_cnt, {31'd0, scen[s].fence});
            check32({scen[s].name, "_fence_ar_overlap"}, overlap_cnt, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
